// File: rtl/ram_arbiter.sv
// Two-master arbiter for the shared ram bus: master 0 has priority, master 1 is protected by a starvation guard.
// Define RAM_ARB_ROUND_ROBIN_EN to replace the guard with alternating round-robin arbitration.
module ram_arbiter
`ifdef RAM_ARB_ROUND_ROBIN_EN
(
`else
#(
   parameter int MAX_WAIT = 4
) (
`endif
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_en,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [24:0] m0_addr,
   input  logic [31:0] m0_data_in,
   output logic [31:0] m0_data_out,
   output logic        m0_wt,
   input  logic        m1_en,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [24:0] m1_addr,
   input  logic [31:0] m1_data_in,
   output logic [31:0] m1_data_out,
   output logic        m1_wt,
   output logic        ram_en,
   output logic        ram_wr,
   output logic [1:0]  ram_size,
   output logic [24:0] ram_addr,
   output logic [31:0] ram_data_in,
   input  logic [31:0] ram_data_out,
   input  logic        ram_wt,
   output logic        busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT0  = 2'd1;
   localparam logic [1:0] GRANT1  = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   logic [1:0] state;
   logic [1:0] state_nxt;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_grant;
   logic last_grant_nxt;
`else
   localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);
   logic [3:0] starve_cnt;
   logic [3:0] starve_cnt_nxt;
`endif

   // Arbitration happens only in IDLE; a granted cycle is never preempted.
   always_comb begin
      state_nxt = state;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_grant_nxt = last_grant;
`else
      starve_cnt_nxt = starve_cnt;
`endif
      case (state)
         IDLE: begin
            if (m0_en && m1_en) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
               state_nxt      = last_grant ? GRANT0 : GRANT1;
               last_grant_nxt = ~last_grant;
`else
               if (starve_cnt < MAX_WAIT_CNT) begin
                  state_nxt      = GRANT0;
                  starve_cnt_nxt = starve_cnt + 4'd1;
               end else begin
                  state_nxt      = GRANT1;
                  starve_cnt_nxt = 4'd0;
               end
`endif
            end else if (m0_en) begin
               state_nxt = GRANT0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
               last_grant_nxt = 1'b0;
`else
               starve_cnt_nxt = 4'd0;
`endif
            end else if (m1_en) begin
               state_nxt = GRANT1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
               last_grant_nxt = 1'b1;
`else
               starve_cnt_nxt = 4'd0;
`endif
            end
         end
         GRANT0, GRANT1: begin
            if (!ram_wt) state_nxt = RELEASE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_grant <= 1'b1;
`else
         starve_cnt <= 4'd0;
`endif
      end else begin
         state <= state_nxt;
`ifdef RAM_ARB_ROUND_ROBIN_EN
         last_grant <= last_grant_nxt;
`else
         starve_cnt <= starve_cnt_nxt;
`endif
      end
   end

   // Master 0's fields are the idle default so the ram bus never floats to X.
   logic sel1;
   assign sel1        = (state == GRANT1);
   assign ram_en      = (state == GRANT0) || (state == GRANT1);
   assign ram_wr      = sel1 ? m1_wr      : m0_wr;
   assign ram_size    = sel1 ? m1_size    : m0_size;
   assign ram_addr    = sel1 ? m1_addr    : m0_addr;
   assign ram_data_in = sel1 ? m1_data_in : m0_data_in;

   assign m0_wt       = (state == GRANT0) ? ram_wt : 1'b1;
   assign m1_wt       = (state == GRANT1) ? ram_wt : 1'b1;
   assign m0_data_out = ram_data_out;
   assign m1_data_out = ram_data_out;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small ram model that completes each access two cycles after ram_en.
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_en = 1'b0, m0_wr = 1'b0;
   logic [1:0]  m0_size = 2'b00;
   logic [24:0] m0_addr = '0;
   logic [31:0] m0_data_in = '0;
   logic [31:0] m0_data_out;
   logic        m0_wt;
   logic        m1_en = 1'b0, m1_wr = 1'b0;
   logic [1:0]  m1_size = 2'b00;
   logic [24:0] m1_addr = '0;
   logic [31:0] m1_data_in = '0;
   logic [31:0] m1_data_out;
   logic        m1_wt;
   logic        ram_en, ram_wr;
   logic [1:0]  ram_size;
   logic [24:0] ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out = '0;
   logic        ram_wt = 1'b1;
   logic        busy;

   int errors = 0;
   int checks = 0;
   logic [31:0] rdata = 32'h12345678;
   int rcnt = 0;

   always #5 clk = ~clk;

   ram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_en(m0_en), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_data_in(m0_data_in), .m0_data_out(m0_data_out), .m0_wt(m0_wt),
      .m1_en(m1_en), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_data_in(m1_data_in), .m1_data_out(m1_data_out), .m1_wt(m1_wt),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_size(ram_size), .ram_addr(ram_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .ram_wt(ram_wt),
      .busy(busy)
   );

   // Ram model: wait low for one cycle on the second falling edge of a request.
   always @(negedge clk) begin
      if (reset || !ram_en) begin
         rcnt   = 0;
         ram_wt = 1'b1;
      end else begin
         rcnt++;
         if (rcnt == 2) begin
            ram_wt       = 1'b0;
            ram_data_out = rdata;
         end else begin
            ram_wt = 1'b1;
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%0b exp=0", ram_en); end
      checks++; if (m0_wt !== 1'b1) begin errors++; $display("FAIL reset_m0_wt got=%0b exp=1", m0_wt); end
      checks++; if (m1_wt !== 1'b1) begin errors++; $display("FAIL reset_m1_wt got=%0b exp=1", m1_wt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_single_read();
      int n;
      @(posedge clk); #1;
      m1_en = 1'b1; m1_wr = 1'b0; m1_size = 2'b10; m1_addr = 25'h0000100;
      rdata = 32'h12345678;
      checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL single_same_cycle got=%0b exp=0", ram_en); end
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL single_ram_en got=%0b exp=1", ram_en); end
      checks++; if (ram_addr !== 25'h0000100) begin errors++; $display("FAIL single_addr got=%h exp=0000100", ram_addr); end
      checks++; if (ram_size !== 2'b10 || ram_wr !== 1'b0) begin errors++; $display("FAIL single_ctl got=%b/%b exp=10/0", ram_size, ram_wr); end
      n = 0;
      do begin
         @(negedge clk); #1; n++;
         checks++; if (m0_wt !== 1'b1) begin errors++; $display("FAIL single_m0_wt got=%0b exp=1", m0_wt); end
      end while (m1_wt !== 1'b0 && n < 10);
      checks++; if (m1_wt !== 1'b0) begin errors++; $display("FAIL single_m1_wt_timeout got=%0b exp=0", m1_wt); end
      checks++; if (m1_data_out !== 32'h12345678) begin errors++; $display("FAIL single_data got=%h exp=12345678", m1_data_out); end
      @(posedge clk); #1;
      m1_en = 1'b0;
      checks++; if (ram_en !== 1'b0 || busy !== 1'b1 || m1_wt !== 1'b1) begin errors++; $display("FAIL single_release got en=%0b busy=%0b wt=%0b exp 0/1/1", ram_en, busy, m1_wt); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", busy); end
   endtask

   task automatic test_contention();
      logic exp_order [10];
      logic got;
      int n;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      do_reset();
      m0_en = 1'b1; m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 25'h0000A00;
      m1_en = 1'b1; m1_wr = 1'b0; m1_size = 2'b10; m1_addr = 25'h0000B00;
      for (int g = 0; g < 10; g++) begin
         n = 0;
         while (ram_en !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
         got = (ram_addr == 25'h0000B00);
         checks++;
         if (ram_en !== 1'b1 || got !== exp_order[g]) begin
            errors++; $display("FAIL contention_grant%0d got=%0b en=%0b exp=%0b", g, got, ram_en, exp_order[g]);
         end
         n = 0;
         while (ram_en === 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      end
      m0_en = 1'b0; m1_en = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int n;
      m0_en = 1'b1; m0_wr = 1'b1; m0_size = 2'b00; m0_addr = 25'h0000010; m0_data_in = 32'h000000AB;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (m0_wt !== 1'b0 && n < 10);
      checks++; if (m0_wt !== 1'b0) begin errors++; $display("FAIL b2b_wr_timeout got=%0b exp=0", m0_wt); end
      checks++; if (ram_wr !== 1'b1 || ram_size !== 2'b00 || ram_data_in !== 32'h000000AB) begin
         errors++; $display("FAIL b2b_wr_fields got wr=%0b size=%b data=%h exp 1/00/000000ab", ram_wr, ram_size, ram_data_in); end
      @(negedge clk); #1;
      checks++; if (m0_wt !== 1'b1 || ram_en !== 1'b0) begin errors++; $display("FAIL b2b_release got wt=%0b en=%0b exp 1/0", m0_wt, ram_en); end
      m0_wr = 1'b0; m0_size = 2'b01; m0_addr = 25'h0000020; rdata = 32'hCAFE0123;
      @(negedge clk); #1;
      checks++; if (ram_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got en=%0b busy=%0b exp 0/0", ram_en, busy); end
      @(negedge clk); #1;
      checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b0 || ram_size !== 2'b01 || ram_addr !== 25'h0000020) begin
         errors++; $display("FAIL b2b_rd_fields got en=%0b wr=%0b size=%b addr=%h exp 1/0/01/0000020", ram_en, ram_wr, ram_size, ram_addr); end
      n = 0;
      do begin @(negedge clk); #1; n++; end while (m0_wt !== 1'b0 && n < 10);
      checks++; if (m0_wt !== 1'b0 || m0_data_out !== 32'hCAFE0123) begin errors++; $display("FAIL b2b_rd_done got wt=%0b data=%h exp 0/cafe0123", m0_wt, m0_data_out); end
      m0_en = 1'b0;
      @(negedge clk); #1;
      checks++; if (m0_wt !== 1'b1) begin errors++; $display("FAIL b2b_rd_wt_width got=%0b exp=1", m0_wt); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_late_m1();
      int n;
      @(posedge clk); #1;
      m0_en = 1'b1; m0_wr = 1'b0; m0_size = 2'b10; m0_addr = 25'h0000A40;
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b1 || ram_addr !== 25'h0000A40) begin errors++; $display("FAIL late_g0 got en=%0b addr=%h exp 1/0000a40", ram_en, ram_addr); end
      m1_en = 1'b1; m1_wr = 1'b0; m1_size = 2'b10; m1_addr = 25'h0001B00;
      n = 0;
      do begin
         @(negedge clk); #1; n++;
         checks++; if (ram_addr !== 25'h0000A40 || m1_wt !== 1'b1) begin errors++; $display("FAIL late_hold got addr=%h m1_wt=%0b exp 0000a40/1", ram_addr, m1_wt); end
      end while (m0_wt !== 1'b0 && n < 10);
      m0_en = 1'b0;
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL late_release got en=%0b busy=%0b exp 0/1", ram_en, busy); end
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL late_idle got en=%0b busy=%0b exp 0/0", ram_en, busy); end
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b1 || ram_addr !== 25'h0001B00) begin errors++; $display("FAIL late_g1 got en=%0b addr=%h exp 1/0001b00", ram_en, ram_addr); end
      n = 0;
      do begin @(negedge clk); #1; n++; end while (m1_wt !== 1'b0 && n < 10);
      checks++; if (m1_wt !== 1'b0) begin errors++; $display("FAIL late_g1_timeout got=%0b exp=0", m1_wt); end
      m1_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m1_en = 1'b1; m1_wr = 1'b1; m1_size = 2'b10; m1_addr = 25'h0000300; m1_data_in = 32'h55AA55AA;
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b1 || ram_addr !== 25'h0000300) begin errors++; $display("FAIL mid_grant got en=%0b addr=%h exp 1/0000300", ram_en, ram_addr); end
      reset = 1'b1; m1_en = 1'b0;
      @(posedge clk); #1;
      checks++; if (ram_en !== 1'b0 || m1_wt !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset got en=%0b m1_wt=%0b busy=%0b exp 0/1/0", ram_en, m1_wt, busy); end
`ifndef RAM_ARB_ROUND_ROBIN_EN
      checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL mid_starve got=%0d exp=0", dut.starve_cnt); end
`endif
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_after got busy=%0b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_back_to_back();
      test_late_m1();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
